r2r_dac_seq: RTL and testbench
==============================

R2R_DAC_SEQ -- requirements
Module: r2r_dac_seq

Interface
REQ-001 Parameter WIDTH, default 8: DAC code width in bits, legal range 4..12.
REQ-002 Parameter DEPTH, default 4: sample FIFO entries, power of two, legal range 2..16.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous reset, active-low, sampled on the rising edge of clk.
REQ-005 ena  input  1  enable; low freezes the prescaler and all code updates.
REQ-006 mode  input  2  00 DIRECT, 01 FIFO, 10 RAMP, 11 HOLD.
REQ-007 div  input  8  sample-rate divider; one tick every div+1 enabled cycles.
REQ-008 wr_en  input  1  one-cycle write strobe for wr_data.
REQ-009 wr_data  input  WIDTH  sample value to write.
REQ-010 clr  input  1  one-cycle pulse: flush the FIFO and clear the sticky flags.
REQ-011 dac_code  output  WIDTH  registered code driving the R2R ladder bits.
REQ-012 sample_strobe  output  1  one-cycle pulse in the cycle dac_code takes a new value.
REQ-013 full, empty  output  1 each  FIFO status flags, registered.
REQ-014 level  output  clog2(DEPTH+1)  number of FIFO entries held.
REQ-015 overflow, underrun  output  1 each  sticky error flags.

Function
REQ-016 Prescaler counter shall count 0..div while ena=1, then wrap to 0; tick is asserted when counter==div and ena=1. div=0 shall give a tick every enabled cycle.
REQ-017 A change in mode, sampled against the previous cycle's mode, shall reset the prescaler to 0 with no tick in that cycle.
REQ-018 DIRECT: on wr_en=1 with ena=1, dac_code shall become wr_data one cycle later with sample_strobe=1; ticks are ignored; the FIFO is not written.
REQ-019 FIFO: wr_en with not full shall push wr_data; wr_en while full shall drop the data and set overflow.
REQ-020 FIFO: on tick with not empty, the oldest entry shall load into dac_code with sample_strobe=1; on tick with empty, dac_code shall hold and underrun shall be set.
REQ-021 FIFO full with push and tick in the same cycle: the pop and the push shall both occur, level shall stay DEPTH, and overflow shall not be set.
REQ-022 FIFO empty with push and tick in the same cycle: underrun shall be set, the push shall be stored, and there shall be no bypass to dac_code.
REQ-023 RAMP: a 2-state machine (UP, DOWN). On each tick, dac_code shall step +1 in UP and -1 in DOWN, with sample_strobe=1.
REQ-024 RAMP: in UP at code 2^WIDTH-1, the next tick shall switch the state to DOWN and output 2^WIDTH-2. In DOWN at code 0, the next tick shall switch to UP and output 1. There is no wrap-around and no repeated endpoint.
REQ-025 RAMP entry from another mode shall start from the current dac_code with state UP. Writes in RAMP shall push to the FIFO per REQ-019.
REQ-026 HOLD: dac_code and sample_strobe=0 shall be frozen; FIFO writes follow REQ-019; no pops occur.
REQ-027 ena=0: no ticks, no dac_code change, sample_strobe=0; FIFO writes are still accepted.
REQ-028 clr shall empty the FIFO (level=0) and clear overflow and underrun next cycle. clr has priority over a simultaneous push, pop or flag set; dac_code is unaffected.
REQ-029 full shall be 1 iff level==DEPTH; empty shall be 1 iff level==0; both update in the same cycle as level.

Reset
REQ-030 With rst_n=0 at a clock edge, the following shall hold next cycle:
- dac_code=0, sample_strobe=0, level=0, empty=1, full=0, overflow=0, underrun=0;
- prescaler=0, ramp state UP, FIFO pointers 0.
REQ-031 Reset mid-operation shall abort any pending pop, push or ramp step and discard the FIFO contents.
REQ-032 The first tick after reset release shall occur div+1 enabled cycles after release.

Verification
REQ-033 DIRECT, WIDTH=8: wr_data=0xA5 with wr_en -> dac_code=0xA5 and sample_strobe=1 exactly one cycle later.
REQ-034 FIFO, div=3, DEPTH=4: push 0x10,0x20,0x30,0x40 -> full=1; a 5th push sets overflow; codes appear every 4 cycles in order; the 5th tick sets underrun and dac_code stays 0x40.
REQ-035 RAMP, div=0, WIDTH=4, start at 0 -> codes 1..15, then 14..0, then 1; one strobe per cycle.
REQ-036 FIFO full plus wr_en and tick in the same cycle -> level stays 4, overflow=0, the new entry is popped last.
REQ-037 rst_n=0 for one cycle during a RAMP at code 0x7F -> all outputs take their REQ-030 values next cycle; the first strobe comes div+1 cycles after release.
REQ-038 ena=0 for 10 cycles in FIFO mode with data queued -> no strobe and dac_code constant; the prescaler resumes from its frozen count.

Source files
------------

// File: rtl/r2r_dac_seq.sv
// Sequencer for an R2R ladder DAC: direct writes, FIFO playback at a divided
// sample rate, or a triangle ramp, all producing one registered code word.
module r2r_dac_seq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic [1:0]                 mode,
  input  logic [7:0]                 div,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       clr,
  output logic [WIDTH-1:0]           dac_code,
  output logic                       sample_strobe,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       underrun
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0]    DEPTH_L  = LW'(DEPTH);
  localparam logic [WIDTH-1:0] CODE_MAX = '1;

  typedef enum logic [1:0] {
    M_DIRECT = 2'b00,
    M_FIFO   = 2'b01,
    M_RAMP   = 2'b10,
    M_HOLD   = 2'b11
  } mode_e;

  typedef enum logic {
    RAMP_UP   = 1'b0,
    RAMP_DOWN = 1'b1
  } ramp_e;

  logic [1:0]       mode_q;
  logic [7:0]       cnt_q, cnt_d;
  ramp_e            ramp_q, ramp_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic             strobe_q, strobe_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             und_q, und_d;
  logic [WIDTH-1:0] mem [DEPTH];

  logic mode_chg, tick, fifo_tick, push_req, push, pop;

  // Prescaler: a mode change restarts the sample period without a tick.
  always_comb begin
    mode_chg = (mode != mode_q);
    tick     = ena && !mode_chg && (cnt_q == div);
    cnt_d    = cnt_q;
    if (mode_chg) begin
      cnt_d = '0;
    end else if (ena) begin
      cnt_d = (cnt_q >= div) ? '0 : cnt_q + 8'd1;
    end
  end

  // FIFO control; clr overrides every push, pop and flag update.
  always_comb begin
    fifo_tick = tick && (mode == M_FIFO);
    push_req  = wr_en && (mode != M_DIRECT) && !clr;
    pop       = fifo_tick && !empty_q && !clr;
    push      = push_req && (!full_q || pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    und_d    = und_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      und_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop) level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
      if (push_req && full_q && !pop) ovf_d = 1'b1;
      if (fifo_tick && empty_q) und_d = 1'b1;
    end
    full_d  = (level_d == DEPTH_L);
    empty_d = (level_d == '0);
  end

  // Ramp FSM next state; leaving RAMP parks it in UP so re-entry climbs first.
  always_comb begin
    ramp_d = ramp_q;
    if (mode != M_RAMP) begin
      ramp_d = RAMP_UP;
    end else if (tick) begin
      case (ramp_q)
        RAMP_UP:   if (code_q == CODE_MAX) ramp_d = RAMP_DOWN;
        RAMP_DOWN: if (code_q == '0) ramp_d = RAMP_UP;
        default:   ramp_d = RAMP_UP;
      endcase
    end
  end

  // Code output: the endpoints bounce instead of wrapping.
  always_comb begin
    code_d   = code_q;
    strobe_d = 1'b0;
    case (mode)
      M_DIRECT: begin
        if (wr_en && ena) begin
          code_d   = wr_data;
          strobe_d = 1'b1;
        end
      end
      M_FIFO: begin
        if (pop) begin
          code_d   = mem[rd_ptr_q];
          strobe_d = 1'b1;
        end
      end
      M_RAMP: begin
        if (tick) begin
          strobe_d = 1'b1;
          if (ramp_q == RAMP_UP)
            code_d = (code_q == CODE_MAX) ? CODE_MAX - WIDTH'(1) : code_q + WIDTH'(1);
          else
            code_d = (code_q == '0) ? WIDTH'(1) : code_q - WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ramp_q <= RAMP_UP;
    else        ramp_q <= ramp_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q   <= mode;
      cnt_q    <= '0;
      code_q   <= '0;
      strobe_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      mode_q   <= mode;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      strobe_q <= strobe_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      und_q    <= und_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (rst_n && push && (wr_ptr_q == AW'(gi))) mem[gi] <= wr_data;
      end
    end
  endgenerate

  assign dac_code      = code_q;
  assign sample_strobe = strobe_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign level         = level_q;
  assign overflow      = ovf_q;
  assign underrun      = und_q;

endmodule

// File: tb/tb_r2r_dac_seq.sv
// Directed bench for r2r_dac_seq: an 8-bit instance for direct/FIFO/reset
// behaviour and a 4-bit instance for the full ramp sweep.
module tb_r2r_dac_seq;

  logic       clk = 1'b0;
  logic       rst_n, ena, wr_en, clr;
  logic [1:0] mode;
  logic [7:0] div;
  logic [7:0] wr_data;

  logic [7:0] code8;
  logic       stb8, full8, empty8, ovf8, und8;
  logic [2:0] lvl8;
  logic [3:0] code4;
  logic       stb4, full4, empty4, ovf4, und4;
  logic [2:0] lvl4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  r2r_dac_seq #(.WIDTH(8), .DEPTH(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .div(div),
    .wr_en(wr_en), .wr_data(wr_data), .clr(clr),
    .dac_code(code8), .sample_strobe(stb8), .full(full8), .empty(empty8),
    .level(lvl8), .overflow(ovf8), .underrun(und8)
  );

  r2r_dac_seq #(.WIDTH(4), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .div(div),
    .wr_en(wr_en), .wr_data(wr_data[3:0]), .clr(clr),
    .dac_code(code4), .sample_strobe(stb4), .full(full4), .empty(empty4),
    .level(lvl4), .overflow(ovf4), .underrun(und4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int exp4;
    logic [7:0] fifo_codes [4];
    logic [7:0] g_codes [4];
    fifo_codes[0] = 8'h10; fifo_codes[1] = 8'h20; fifo_codes[2] = 8'h30; fifo_codes[3] = 8'h40;
    g_codes[0] = 8'h22; g_codes[1] = 8'h33; g_codes[2] = 8'h44; g_codes[3] = 8'h55;

    rst_n = 1'b0; ena = 1'b1; mode = 2'b00; div = 8'd0;
    wr_en = 1'b0; wr_data = 8'h00; clr = 1'b0;
    steps(2);
    chk("rst_code", 32'(code8), 32'h0);
    chk("rst_strobe", 32'(stb8), 32'h0);
    chk("rst_level", 32'(lvl8), 32'h0);
    chk("rst_empty", 32'(empty8), 32'h1);
    chk("rst_full", 32'(full8), 32'h0);
    chk("rst_ovf", 32'(ovf8), 32'h0);
    chk("rst_und", 32'(und8), 32'h0);
    chk("rst4_code", 32'(code4), 32'h0);
    chk("rst4_flags", {27'd0, lvl4, full4, ovf4}, 32'h0);
    chk("rst4_empty", {30'd0, empty4, und4}, 32'h2);

    // DIRECT write lands one cycle later
    rst_n = 1'b1;
    wr_en = 1'b1; wr_data = 8'hA5;
    step();
    chk("direct_code", 32'(code8), 32'hA5);
    chk("direct_strobe", 32'(stb8), 32'h1);
    wr_en = 1'b0;
    step();
    chk("direct_strobe_off", 32'(stb8), 32'h0);
    chk("direct_no_fifo", 32'(lvl8), 32'h0);

    // Fill in HOLD, then overflow
    mode = 2'b11;
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = fifo_codes[i];
      step();
    end
    chk("fill_level", 32'(lvl8), 32'h4);
    chk("fill_full", 32'(full8), 32'h1);
    chk("fill_ovf", 32'(ovf8), 32'h0);
    chk("hold_code", 32'(code8), 32'hA5);
    wr_data = 8'h50;
    step();
    chk("ovf_set", 32'(ovf8), 32'h1);
    chk("ovf_level", 32'(lvl8), 32'h4);
    wr_en = 1'b0;

    // FIFO playback, div=3: a code every 4 cycles
    mode = 2'b01; div = 8'd3;
    step();
    chk("fifo_modechg_strobe", 32'(stb8), 32'h0);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        step();
        chk("fifo_idle_strobe", 32'(stb8), 32'h0);
      end
      step();
      chk("fifo_code", 32'(code8), 32'(fifo_codes[k]));
      chk("fifo_strobe", 32'(stb8), 32'h1);
    end
    chk("fifo_drained_empty", 32'(empty8), 32'h1);
    chk("fifo_drained_und", 32'(und8), 32'h0);
    steps(3);
    step();
    chk("underrun_set", 32'(und8), 32'h1);
    chk("underrun_code", 32'(code8), 32'h40);
    chk("underrun_strobe", 32'(stb8), 32'h0);

    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_ovf", 32'(ovf8), 32'h0);
    chk("clr_und", 32'(und8), 32'h0);
    chk("clr_code", 32'(code8), 32'h40);

    // Full + push + tick in one cycle
    mode = 2'b11; wr_en = 1'b1;
    wr_data = 8'h11; step();
    wr_data = 8'h22; step();
    wr_data = 8'h33; step();
    wr_data = 8'h44; step();
    wr_en = 1'b0; mode = 2'b01;
    step();
    steps(3);
    wr_en = 1'b1; wr_data = 8'h55;
    step();
    wr_en = 1'b0;
    chk("fullpush_code", 32'(code8), 32'h11);
    chk("fullpush_level", 32'(lvl8), 32'h4);
    chk("fullpush_full", 32'(full8), 32'h1);
    chk("fullpush_ovf", 32'(ovf8), 32'h0);
    for (int k = 0; k < 4; k++) begin
      steps(3);
      step();
      chk("fullpush_order", 32'(code8), 32'(g_codes[k]));
    end
    chk("fullpush_empty", 32'(empty8), 32'h1);

    // Empty + push + tick: underrun, stored, no bypass
    steps(3);
    wr_en = 1'b1; wr_data = 8'h66;
    step();
    wr_en = 1'b0;
    chk("emptypush_und", 32'(und8), 32'h1);
    chk("emptypush_level", 32'(lvl8), 32'h1);
    chk("emptypush_code", 32'(code8), 32'h55);
    chk("emptypush_strobe", 32'(stb8), 32'h0);
    steps(3);
    step();
    chk("emptypush_later", 32'(code8), 32'h66);

    // ena=0 freezes the prescaler mid-count
    wr_en = 1'b1;
    wr_data = 8'h77; step();
    wr_data = 8'h88; step();
    ena = 1'b0; wr_data = 8'h99;
    step();
    wr_en = 1'b0;
    chk("ena0_push_level", 32'(lvl8), 32'h3);
    chk("ena0_strobe", 32'(stb8), 32'h0);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("ena0_strobe", 32'(stb8), 32'h0);
      chk("ena0_code", 32'(code8), 32'h66);
    end
    ena = 1'b1;
    step();
    chk("resume_no_tick", 32'(stb8), 32'h0);
    step();
    chk("resume_tick_strobe", 32'(stb8), 32'h1);
    chk("resume_tick_code", 32'(code8), 32'h77);

    // Reset during RAMP at 0x7F
    mode = 2'b00; wr_en = 1'b1; wr_data = 8'h7F;
    step();
    wr_en = 1'b0; mode = 2'b10; div = 8'd2;
    step();
    chk("ramp_pre_code", 32'(code8), 32'h7F);
    chk("ramp_pre_level", 32'(lvl8), 32'h2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_code", 32'(code8), 32'h0);
    chk("midrst_strobe", 32'(stb8), 32'h0);
    chk("midrst_level", 32'(lvl8), 32'h0);
    chk("midrst_empty", 32'(empty8), 32'h1);
    chk("midrst_flags", {29'd0, full8, ovf8, und8}, 32'h0);
    step();
    chk("release_strobe1", 32'(stb8), 32'h0);
    step();
    chk("release_strobe2", 32'(stb8), 32'h0);
    step();
    chk("release_first_strobe", 32'(stb8), 32'h1);
    chk("release_first_code", 32'(code8), 32'h01);

    // Full 4-bit triangle sweep, div=0
    rst_n = 1'b0; div = 8'd0; mode = 2'b10;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 31; k++) begin
      exp4 = (k < 15) ? k + 1 : ((k < 30) ? 29 - k : 1);
      step();
      chk("ramp4_code", 32'(code4), 32'(exp4));
      chk("ramp4_strobe", 32'(stb4), 32'h1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
